// File: rtl/hilo_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_ctrl
//
// Owns the HI/LO architectural registers and sequences every write to them:
// single-cycle MULT/MULTU, iterative restoring DIV/DIVU, and MTHI/MTLO.
// The block sits beside EX and stalls the pipeline through busy while a
// multi-cycle operation is in flight. Its hi/lo outputs feed the write-back
// select path for MFHI/MFLO.
//
// Ports
//   clk        core clock, all state updates on the rising edge
//   resetn     asynchronous, active-low reset
//   req_valid  request present this cycle
//   req_op     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   src_a      rs value (dividend / multiplicand / MTHI-MTLO data)
//   src_b      rt value (divisor / multiplier)
//   flush      abort any in-flight operation and drop a same-cycle request
//   busy       high while the sequencer is not idle
//   done       one-cycle pulse when a MULT/DIV result is committed
//   hi, lo     current HI / LO register contents
// ---------------------------------------------------------------------------
module hilo_muldiv_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_t;

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   hi_reg, hi_next;
    logic [DATA_W-1:0]   lo_reg, lo_next;
    logic                done_reg, done_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    // opa: multiplicand, or dividend magnitude shifting out while quotient
    // bits shift in. opb: multiplier, or divisor magnitude.
    logic [DATA_W-1:0]   opa_reg, opa_next;
    logic [DATA_W-1:0]   opb_reg, opb_next;
    logic                sgn_reg, sgn_next;
    logic [DATA_W:0]     rem_reg, rem_next;
    logic                q_neg_reg, q_neg_next;
    logic                r_neg_reg, r_neg_next;
    logic                dz_reg, dz_next;

    // Request-side helpers
    logic                req_signed;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;

    // Datapath helpers
    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;
    logic [2*DATA_W-1:0] product;
    logic [DATA_W+1:0]   rem_shift;
    logic [DATA_W+1:0]   diff;
    logic                take;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    assign req_signed = ~req_op[0];
    assign a_mag = (req_signed && src_a[DATA_W-1]) ? (~src_a + 1'b1) : src_a;
    assign b_mag = (req_signed && src_b[DATA_W-1]) ? (~src_b + 1'b1) : src_b;

    // Sign-extend (or zero-extend) to 2*DATA_W; the truncated product of the
    // extended operands is the exact two's-complement result either way.
    assign a_ext   = {{DATA_W{sgn_reg & opa_reg[DATA_W-1]}}, opa_reg};
    assign b_ext   = {{DATA_W{sgn_reg & opb_reg[DATA_W-1]}}, opb_reg};
    assign product = a_ext * b_ext;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor; a clear top bit means no borrow.
    assign rem_shift = {rem_reg, opa_reg[DATA_W-1]};
    assign diff      = rem_shift - {2'b00, opb_reg};
    assign take      = ~diff[DATA_W+1];

    assign quo_fix = q_neg_reg ? (~opa_reg + 1'b1) : opa_reg;
    assign rem_fix = r_neg_reg ? (~rem_reg[DATA_W-1:0] + 1'b1) : rem_reg[DATA_W-1:0];

    always_comb begin
        state_next = state_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        done_next  = 1'b0;
        cnt_next   = cnt_reg;
        opa_next   = opa_reg;
        opb_next   = opb_reg;
        sgn_next   = sgn_reg;
        rem_next   = rem_reg;
        q_neg_next = q_neg_reg;
        r_neg_next = r_neg_reg;
        dz_next    = dz_reg;

        case (state_reg)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    case (req_op)
                        OP_MTHI: hi_next = src_a;
                        OP_MTLO: lo_next = src_a;
                        OP_MULT, OP_MULTU: begin
                            opa_next   = src_a;
                            opb_next   = src_b;
                            sgn_next   = req_signed;
                            state_next = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            opa_next   = a_mag;
                            opb_next   = b_mag;
                            sgn_next   = req_signed;
                            rem_next   = '0;
                            cnt_next   = '0;
                            q_neg_next = req_signed & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                            r_neg_next = req_signed & src_a[DATA_W-1];
                            dz_next    = (src_b == '0);
                            state_next = ST_DIV;
                        end
                        default: ;
                    endcase
                end
            end

            ST_MUL: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    hi_next    = product[2*DATA_W-1:DATA_W];
                    lo_next    = product[DATA_W-1:0];
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end

            ST_DIV: begin
                // DATA_W quotient-bit steps at counts 0..DATA_W-1, then one
                // more cycle at count DATA_W before FIX, so the commit lands
                // DATA_W+2 edges after the accept edge.
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == CNT_W'(DATA_W)) begin
                    state_next = ST_FIX;
                end else begin
                    rem_next = take ? diff[DATA_W:0] : rem_shift[DATA_W:0];
                    opa_next = {opa_reg[DATA_W-2:0], take};
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_FIX: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    // A zero divisor still reports completion but leaves
                    // HI/LO untouched.
                    if (!dz_reg) begin
                        lo_next = quo_fix;
                        hi_next = rem_fix;
                    end
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
            hi_reg    <= '0;
            lo_reg    <= '0;
            done_reg  <= 1'b0;
            cnt_reg   <= '0;
            opa_reg   <= '0;
            opb_reg   <= '0;
            sgn_reg   <= 1'b0;
            rem_reg   <= '0;
            q_neg_reg <= 1'b0;
            r_neg_reg <= 1'b0;
            dz_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            done_reg  <= done_next;
            cnt_reg   <= cnt_next;
            opa_reg   <= opa_next;
            opb_reg   <= opb_next;
            sgn_reg   <= sgn_next;
            rem_reg   <= rem_next;
            q_neg_reg <= q_neg_next;
            r_neg_reg <= r_neg_next;
            dz_reg    <= dz_next;
        end
    end

    assign busy = (state_reg != ST_IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv_ctrl
//
// Directed stimulus with hand-computed expected HI/LO values. Each MULT/DIV
// issue pushes its expected result and commit cycle onto a scoreboard; an
// independent monitor pops and compares whenever done pulses.
// ---------------------------------------------------------------------------
module tb_hilo_muldiv_ctrl;

    localparam int DATA_W = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_RSVD  = 3'b110;

    localparam int LAT_MUL = 1;
    localparam int LAT_DIV = DATA_W + 2;

    logic              clk;
    logic              resetn;
    logic              req_valid;
    logic [2:0]        req_op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              flush;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    hilo_muldiv_ctrl #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_op    (req_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    typedef struct {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        int                cyc;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (resetn) begin
            if (done) begin
                check("done_not_2_cycles", 64'(prev_done), 64'd0);
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_hi", 64'(hi), 64'(e.hi));
                    check("result_lo", 64'(lo), 64'(e.lo));
                    check("result_cycle", 64'(cycle_cnt), 64'(e.cyc));
                end
            end
            prev_done <= done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    // Drives one request for a single cycle; called just after a negedge and
    // returns at the negedge following the accept edge.
    task automatic send(input logic [2:0] op, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b, input bit push,
                        input logic [DATA_W-1:0] ehi, input logic [DATA_W-1:0] elo,
                        input int lat);
        exp_t e;
        req_valid = 1'b1;
        req_op    = op;
        src_a     = a;
        src_b     = b;
        if (push) begin
            e.hi  = ehi;
            e.lo  = elo;
            e.cyc = cycle_cnt + 1 + lat;
            sb.push_back(e);
        end
        $display("txn op=%b a=%h b=%h flush=%0b expect_hi=%h expect_lo=%h", op, a, b, flush, ehi, elo);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("busy_timeout", 64'(busy), 64'd0);
    endtask

    int n;

    initial begin
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        src_a     = '0;
        src_b     = '0;
        flush     = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // MTHI / MTLO
        send(OP_MTHI, 32'h1234, 32'h0, 1'b0, 32'h0, 32'h0, 0);
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_busy", 64'(busy), 64'd0);
        send(OP_MTLO, 32'h5678, 32'h0, 1'b0, 32'h0, 32'h0, 0);
        check("mtlo_lo", 64'(lo), 64'h5678);
        check("mtlo_hi_kept", 64'(hi), 64'h1234);
        check("mtlo_busy", 64'(busy), 64'd0);

        // Multiplies
        send(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, LAT_MUL);
        wait_idle(n);
        check("mult_busy_cycles", 64'(n), 64'd1);
        send(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, LAT_MUL);
        wait_idle(n);
        send(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000, LAT_MUL);
        wait_idle(n);

        // Divides
        send(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT_DIV);
        wait_idle(n);
        check("div_busy_cycles", 64'(n), 64'd34);
        send(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, LAT_DIV);
        wait_idle(n);
        check("divu_busy_cycles", 64'(n), 64'd34);
        send(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD, LAT_DIV);
        wait_idle(n);
        send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, LAT_DIV);
        wait_idle(n);

        // Divide by zero leaves HI/LO alone but still signals done
        send(OP_MTHI, 32'hAA, 32'h0, 1'b0, 32'h0, 32'h0, 0);
        send(OP_MTLO, 32'hBB, 32'h0, 1'b0, 32'h0, 32'h0, 0);
        send(OP_DIVU, 32'd55, 32'd0, 1'b1, 32'hAA, 32'hBB, LAT_DIV);
        wait_idle(n);
        check("divz_busy_cycles", 64'(n), 64'd34);

        // Flush mid-DIV
        send(OP_DIV, 32'd1000, 32'd3, 1'b0, 32'h0, 32'h0, 0);
        repeat (9) @(negedge clk);
        check("flush_pre_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        check("flush_hi", 64'(hi), 64'hAA);
        check("flush_lo", 64'(lo), 64'hBB);
        send(OP_MULT, 32'd5, 32'd6, 1'b1, 32'd0, 32'd30, LAT_MUL);
        wait_idle(n);

        // Flush with a same-cycle MTHI drops it
        flush = 1'b1;
        send(OP_MTHI, 32'h777, 32'h0, 1'b0, 32'h0, 32'h0, 0);
        flush = 1'b0;
        check("flush_mthi_hi", 64'(hi), 64'd0);

        // Flush on the MUL commit edge
        send(OP_MULTU, 32'd9, 32'd9, 1'b0, 32'h0, 32'h0, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_mul_lo", 64'(lo), 64'd30);
        check("flush_mul_busy", 64'(busy), 64'd0);

        // Reserved opcode ignored
        send(OP_RSVD, 32'h1, 32'h2, 1'b0, 32'h0, 32'h0, 0);
        check("rsvd_busy", 64'(busy), 64'd0);
        check("rsvd_lo", 64'(lo), 64'd30);

        // Request while busy, then async reset mid-DIV
        send(OP_DIVU, 32'd100, 32'd7, 1'b0, 32'h0, 32'h0, 0);
        req_valid = 1'b1;
        req_op    = OP_MTHI;
        src_a     = 32'h999;
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
        check("busy_req_hi", 64'(hi), 64'd0);
        check("busy_req_busy", 64'(busy), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_hi", 64'(hi), 64'd0);
        check("midreset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        check("postreset_lo", 64'(lo), 64'd0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
